boss_projectile_launcher: RTL and testbench



---
 rtl/boss_projectile_launcher.sv | 175 +++++++++++++++++
 tb/tb_boss_projectile_launcher.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boss_projectile_launcher.sv
// rtl/boss_projectile_launcher.sv - boss projectile aiming, flight and player-hit detection
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

module boss_projectile_launcher
  import vga_pkg::*;
#(
  parameter int PROJECTILE_COUNT = 4,
  parameter int SPEED            = 8,
  parameter int FIRE_PERIOD      = 90,
  parameter int LIFETIME         = 120,
  parameter int PLAYER_HW        = 20,
  parameter int PLAYER_HH        = 30
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               frame_tick_i,
  input  logic [1:0]                         game_active_i,
  input  logic                               boss_alive_i,
  input  logic                               player_alive_i,
  input  logic [11:0]                        boss_x_i,
  input  logic [11:0]                        boss_y_i,
  input  logic [11:0]                        player_x_i,
  input  logic [11:0]                        player_y_i,
  output logic [PROJECTILE_COUNT-1:0][11:0]  pos_x_proj_o,
  output logic [PROJECTILE_COUNT-1:0][11:0]  pos_y_proj_o,
  output logic [PROJECTILE_COUNT-1:0]        projectile_active_o,
  output logic                               player_hit_o
);

  localparam int                DIAG        = (SPEED * 181) >> 8;
  localparam logic signed [12:0] STEP_P     = 13'(SPEED);
  localparam logic signed [12:0] STEP_N     = 13'(-SPEED);
  localparam logic signed [12:0] DIAG_P     = 13'(DIAG);
  localparam logic signed [12:0] DIAG_N     = 13'(-DIAG);
  localparam logic signed [12:0] HOR_S      = 13'(HOR_PIXELS);
  localparam logic signed [12:0] VER_S      = 13'(VER_PIXELS);
  localparam logic [12:0]        HW_U       = 13'(PLAYER_HW);
  localparam logic [12:0]        HH_U       = 13'(PLAYER_HH);
  localparam logic [15:0]        FIRE_RELOAD = 16'(FIRE_PERIOD);
  localparam logic [15:0]        LIFE_INIT  = 16'(LIFETIME);

  typedef enum logic [1:0] {IDLE, AIM, DIR, LAUNCH} state_e;

  state_e                             state_q;
  logic [15:0]                        cool_q;
  logic [11:0]                        org_x_q, org_y_q;
  logic signed [12:0]                 dx_q, dy_q, step_x_q, step_y_q;
  logic signed [12:0]                 step_x_d, step_y_d;
  logic [12:0]                        ax, ay;
  logic [PROJECTILE_COUNT-1:0][11:0]  px_q, py_q;
  logic [PROJECTILE_COUNT-1:0][12:0]  vx_q, vy_q, nx_v, ny_v;
  logic [PROJECTILE_COUNT-1:0][15:0]  life_q;
  logic [PROJECTILE_COUNT-1:0]        act_q, hit_v, gone_v, launch_oh;
  logic                               run, hit_q;

  function automatic logic [12:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    logic signed [12:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[12] ? 13'(-d) : 13'(d);
  endfunction

  assign run       = (game_active_i == 2'd1) && boss_alive_i && player_alive_i;
  // Lowest clear bit of the active mask; zero when every slot is busy.
  assign launch_oh = ~act_q & (act_q + PROJECTILE_COUNT'(1));

  always_comb begin
    ax       = dx_q[12] ? 13'(-dx_q) : 13'(dx_q);
    ay       = dy_q[12] ? 13'(-dy_q) : 13'(dy_q);
    step_x_d = '0;
    step_y_d = '0;
    if (dx_q == 13'sd0 && dy_q == 13'sd0) begin
      step_y_d = STEP_P;
    end else if ({1'b0, ax} > {ay, 1'b0}) begin
      step_x_d = dx_q[12] ? STEP_N : STEP_P;
    end else if ({1'b0, ay} > {ax, 1'b0}) begin
      step_y_d = dy_q[12] ? STEP_N : STEP_P;
    end else begin
      step_x_d = dx_q[12] ? DIAG_N : DIAG_P;
      step_y_d = dy_q[12] ? DIAG_N : DIAG_P;
    end
  end

  always_comb begin
    for (int i = 0; i < PROJECTILE_COUNT; i++) begin
      hit_v[i]  = act_q[i] && (abs_diff(px_q[i], player_x_i) <= HW_U)
                           && (abs_diff(py_q[i], player_y_i) <= HH_U);
      nx_v[i]   = 13'($signed({1'b0, px_q[i]}) + $signed(vx_q[i]));
      ny_v[i]   = 13'($signed({1'b0, py_q[i]}) + $signed(vy_q[i]));
      gone_v[i] = (life_q[i] == 16'd1)
               || ($signed(nx_v[i]) < 13'sd0) || ($signed(nx_v[i]) >= HOR_S)
               || ($signed(ny_v[i]) < 13'sd0) || ($signed(ny_v[i]) >= VER_S);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cool_q   <= FIRE_RELOAD;
      org_x_q  <= '0;
      org_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      px_q     <= '0;
      py_q     <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      life_q   <= '0;
      act_q    <= '0;
      hit_q    <= 1'b0;
    end else if (!run) begin
      act_q   <= '0;
      state_q <= IDLE;
      cool_q  <= FIRE_RELOAD;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= frame_tick_i && (|hit_v);
      case (state_q)
        IDLE: begin
          if (frame_tick_i) begin
            if (cool_q == 16'd0) begin
              state_q <= AIM;
              cool_q  <= FIRE_RELOAD;
            end else begin
              cool_q <= cool_q - 16'd1;
            end
          end
        end
        AIM: begin
          org_x_q <= boss_x_i;
          org_y_q <= boss_y_i;
          dx_q    <= $signed({1'b0, player_x_i}) - $signed({1'b0, boss_x_i});
          dy_q    <= $signed({1'b0, player_y_i}) - $signed({1'b0, boss_y_i});
          state_q <= DIR;
        end
        DIR: begin
          step_x_q <= step_x_d;
          step_y_q <= step_y_d;
          state_q  <= LAUNCH;
        end
        default: state_q <= IDLE;
      endcase
      // The launch target is always an inactive slot, so it never collides with a move.
      for (int i = 0; i < PROJECTILE_COUNT; i++) begin
        if (frame_tick_i && act_q[i]) begin
          if (hit_v[i] || gone_v[i]) begin
            act_q[i] <= 1'b0;
          end else begin
            px_q[i]   <= nx_v[i][11:0];
            py_q[i]   <= ny_v[i][11:0];
            life_q[i] <= life_q[i] - 16'd1;
          end
        end
        if (state_q == LAUNCH && launch_oh[i]) begin
          act_q[i]  <= 1'b1;
          px_q[i]   <= org_x_q;
          py_q[i]   <= org_y_q;
          vx_q[i]   <= step_x_q;
          vy_q[i]   <= step_y_q;
          life_q[i] <= LIFE_INIT;
        end
      end
    end
  end

  assign pos_x_proj_o        = px_q;
  assign pos_y_proj_o        = py_q;
  assign projectile_active_o = act_q;
  assign player_hit_o        = hit_q;

endmodule

// File: tb/tb_boss_projectile_launcher.sv
// tb/tb_boss_projectile_launcher.sv - three parameterisations checked against a per-frame game model
module tb_boss_projectile_launcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tick, ba, pa;
  logic [1:0]  ga;
  logic [11:0] bx, by, plx, ply;
  logic [3:0][11:0] px_o [3];
  logic [3:0][11:0] py_o [3];
  logic [3:0]       act_o [3];
  logic             hit_o [3];

  boss_projectile_launcher #(.PROJECTILE_COUNT(4), .SPEED(8), .FIRE_PERIOD(90), .LIFETIME(120),
                             .PLAYER_HW(20), .PLAYER_HH(30)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .frame_tick_i(tick), .game_active_i(ga),
    .boss_alive_i(ba), .player_alive_i(pa), .boss_x_i(bx), .boss_y_i(by),
    .player_x_i(plx), .player_y_i(ply), .pos_x_proj_o(px_o[0]), .pos_y_proj_o(py_o[0]),
    .projectile_active_o(act_o[0]), .player_hit_o(hit_o[0]));

  boss_projectile_launcher #(.PROJECTILE_COUNT(4), .SPEED(8), .FIRE_PERIOD(2), .LIFETIME(120),
                             .PLAYER_HW(0), .PLAYER_HH(0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .frame_tick_i(tick), .game_active_i(ga),
    .boss_alive_i(ba), .player_alive_i(pa), .boss_x_i(bx), .boss_y_i(by),
    .player_x_i(plx), .player_y_i(ply), .pos_x_proj_o(px_o[1]), .pos_y_proj_o(py_o[1]),
    .projectile_active_o(act_o[1]), .player_hit_o(hit_o[1]));

  boss_projectile_launcher #(.PROJECTILE_COUNT(4), .SPEED(8), .FIRE_PERIOD(2), .LIFETIME(3),
                             .PLAYER_HW(20), .PLAYER_HH(30)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .frame_tick_i(tick), .game_active_i(ga),
    .boss_alive_i(ba), .player_alive_i(pa), .boss_x_i(bx), .boss_y_i(by),
    .player_x_i(plx), .player_y_i(ply), .pos_x_proj_o(px_o[2]), .pos_y_proj_o(py_o[2]),
    .projectile_active_o(act_o[2]), .player_hit_o(hit_o[2]));

  int p_fp [3] = '{90, 2, 2};
  int p_lt [3] = '{120, 120, 3};
  int p_hw [3] = '{20, 0, 20};
  int p_hh [3] = '{30, 0, 30};

  int m_act [3][4], m_px [3][4], m_py [3][4], m_vx [3][4], m_vy [3][4], m_life [3][4];
  int m_cool [3], m_stage [3], m_ox [3], m_oy [3], m_sx [3], m_sy [3];
  bit m_hit [3];
  int hit_cnt [3];
  int n_chk, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic void aim(input int dx, input int dy, output int sx, output int sy);
    int diag;
    diag = (8 * 181) / 256;
    if (dx == 0 && dy == 0) begin sx = 0; sy = 8; end
    else if (iabs(dx) > 2 * iabs(dy)) begin sx = 8 * sgn(dx); sy = 0; end
    else if (iabs(dy) > 2 * iabs(dx)) begin sx = 0; sy = 8 * sgn(dy); end
    else begin sx = diag * sgn(dx); sy = diag * sgn(dy); end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_act[k][i] = 0; m_px[k][i] = 0; m_py[k][i] = 0;
        m_vx[k][i] = 0; m_vy[k][i] = 0; m_life[k][i] = 0;
      end
      m_cool[k] = p_fp[k]; m_stage[k] = 0; m_hit[k] = 0;
    end
  endfunction

  function automatic void model_step();
    bit run;
    int free, nx, ny;
    run = (ga == 2'd1) && ba && pa;
    for (int k = 0; k < 3; k++) begin
      if (!run) begin
        for (int i = 0; i < 4; i++) m_act[k][i] = 0;
        m_stage[k] = 0; m_cool[k] = p_fp[k]; m_hit[k] = 0;
        continue;
      end
      free = -1;
      for (int i = 3; i >= 0; i--) if (m_act[k][i] == 0) free = i;
      m_hit[k] = 0;
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          if (m_act[k][i] == 0) continue;
          if (iabs(m_px[k][i] - int'(plx)) <= p_hw[k] && iabs(m_py[k][i] - int'(ply)) <= p_hh[k]) begin
            m_act[k][i] = 0; m_hit[k] = 1;
          end else if (m_life[k][i] == 1) begin
            m_act[k][i] = 0;
          end else begin
            nx = m_px[k][i] + m_vx[k][i];
            ny = m_py[k][i] + m_vy[k][i];
            if (nx < 0 || nx >= 1024 || ny < 0 || ny >= 768) m_act[k][i] = 0;
            else begin m_px[k][i] = nx; m_py[k][i] = ny; m_life[k][i]--; end
          end
        end
      end
      case (m_stage[k])
        0: if (tick) begin
             if (m_cool[k] == 0) begin m_stage[k] = 1; m_cool[k] = p_fp[k]; end
             else m_cool[k]--;
           end
        1: begin
             m_ox[k] = int'(bx); m_oy[k] = int'(by);
             aim(int'(plx) - int'(bx), int'(ply) - int'(by), m_sx[k], m_sy[k]);
             m_stage[k] = 2;
           end
        2: m_stage[k] = 3;
        default: begin
          if (free >= 0) begin
            m_act[k][free] = 1; m_px[k][free] = m_ox[k]; m_py[k][free] = m_oy[k];
            m_vx[k][free] = m_sx[k]; m_vy[k][free] = m_sy[k]; m_life[k][free] = p_lt[k];
          end
          m_stage[k] = 0;
        end
      endcase
    end
  endfunction

  task automatic compare_all();
    logic [47:0] ex, ey;
    logic [3:0]  ea;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        ex[i*12 +: 12] = 12'(m_px[k][i]);
        ey[i*12 +: 12] = 12'(m_py[k][i]);
        ea[i]          = (m_act[k][i] != 0);
      end
      check_eq($sformatf("act%0d", k), act_o[k], ea);
      check_eq($sformatf("hit%0d", k), hit_o[k], m_hit[k]);
      check_eq($sformatf("posx%0d", k), px_o[k], ex);
      check_eq($sformatf("posy%0d", k), py_o[k], ey);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    for (int k = 0; k < 3; k++) if (hit_o[k]) hit_cnt[k]++;
    @(negedge clk);
  endtask

  task automatic frames(input int n, input int gap);
    for (int f = 0; f < n; f++) begin
      tick = 1'b1; step(); tick = 1'b0;
      for (int c = 1; c < gap; c++) step();
    end
  endtask

  task automatic set_pos(input int bxv, input int byv, input int pxv, input int pyv);
    bx = 12'(bxv); by = 12'(byv); plx = 12'(pxv); ply = 12'(pyv);
  endtask

  int seen, hb, aborted, fired;

  initial begin
    n_chk = 0; n_fail = 0;
    for (int k = 0; k < 3; k++) hit_cnt[k] = 0;
    rst_n = 1'b0; tick = 1'b0; ga = 2'd1; ba = 1'b1; pa = 1'b1;
    set_pos(512, 300, 812, 300);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check_eq("rst_act_a", act_o[0], 4'h0);
    check_eq("rst_hit_a", hit_o[0], 1'b0);
    rst_n = 1'b1;

    seen = 0;
    for (int f = 0; f < 200 && seen == 0; f++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (hit_o[0]) begin
        seen = 1;
        check_eq("h_x", px_o[0][0], 12'd792);
        check_eq("h_act", act_o[0][0], 1'b0);
        step();
        check_eq("h_pulse", hit_o[0], 1'b0);
      end else begin
        step(); step();
      end
    end
    check_eq("h_seen", seen, 1);

    set_pos(512, 300, 712, 500); ga = 2'd0; step(); ga = 2'd1; frames(10, 4);
    set_pos(512, 300, 520, 700); ga = 2'd0; step(); ga = 2'd1; frames(10, 4);
    set_pos(512, 300, 300, 300); ga = 2'd0; step(); ga = 2'd1; frames(10, 4);

    set_pos(512, 20, 512, 0); ga = 2'd0; step(); ga = 2'd1;
    hb = hit_cnt[1];
    frames(20, 4);
    check_eq("edge_nohit", hit_cnt[1] - hb, 0);

    set_pos(100, 384, 1000, 384); ga = 2'd0; step(); ga = 2'd1;
    frames(16, 5);
    check_eq("exhaust", act_o[1], 4'hF);

    aborted = 0;
    for (int c = 0; c < 100 && aborted == 0; c++) begin
      if (m_stage[1] == 2) begin
        ga = 2'd0; step();
        check_eq("abort_act", act_o[1], 4'h0);
        aborted = 1;
      end else begin
        tick = (c % 5 == 0); step(); tick = 1'b0;
      end
    end
    check_eq("abort_seen", aborted, 1);
    step(); step();
    check_eq("abort_nolaunch", act_o[1], 4'h0);
    ga = 2'd1;
    fired = 0;
    for (int n = 1; n <= 10; n++) begin
      tick = 1'b1; step(); tick = 1'b0;
      repeat (4) step();
      if (act_o[1] != 4'h0 && fired == 0) fired = n;
    end
    check_eq("refire_tick", fired, 3);

    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_eq("arst_act_b", act_o[1], 4'h0);
    check_eq("arst_posx_b", px_o[1], 48'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 20000; c++) begin
      tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) ga = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      if ($urandom_range(0, 499) == 0) ba = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) pa = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 149) == 0) begin
        bx = 12'($urandom_range(0, 1023));
        by = 12'($urandom_range(0, 767));
        if ($urandom_range(0, 1) == 0) begin
          plx = 12'(int'(bx) + int'($urandom_range(0, 160)) - 80);
          ply = 12'(int'(by) + int'($urandom_range(0, 160)) - 80);
        end else begin
          plx = 12'($urandom_range(0, 1023));
          ply = 12'($urandom_range(0, 767));
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
